intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the max cycles irq_o is held without ack_i (legal range 1..255).
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 intr_i  input  1  SHALL be the registered request-valid from the upstream priority encoder.
REQ-005 x_i  input  2  SHALL be the encoded source id (0..3) qualified by intr_i.
REQ-006 mask_i  input  4  SHALL be per-source mask; bit n = 1 blocks source n from being raised.
REQ-007 ack_i  input  1  SHALL be the CPU acknowledge of the raised request.
REQ-008 eoi_i  input  1  SHALL be the CPU end-of-interrupt strobe.
REQ-009 irq_o  output  1  SHALL be the interrupt request to the CPU.
REQ-010 vec_o  output  2  SHALL be the id of the raised/in-service source.
REQ-011 busy_o  output  1  SHALL flag an interrupt in service.
REQ-012 pend_o  output  4  SHALL expose the pending register.
REQ-013 timeout_o  output  1  SHALL pulse one cycle when a request is dropped unacknowledged.

Function
REQ-014 Pending capture: intr_i=1 sampled at an edge SHALL set pend[x_i] at that edge; intr_i=0 leaves pend unchanged; mask_i does not affect capture.
REQ-015 FSM states SHALL be IDLE, REQ, SERV; encoding free.
REQ-016 IDLE: if (pend & ~mask_i) != 0, next edge SHALL go to REQ, latch vec = highest set index of (pend & ~mask_i), clear timer; else stay IDLE.
REQ-017 REQ: irq_o=1, vec_o stable; ack_i=1 SHALL go to SERV at next edge and clear pend[vec] at that edge.
REQ-018 Set/clear collision: intr_i=1 with x_i==vec in the ack cycle SHALL leave pend[vec]=1 (set wins).
REQ-019 REQ timer SHALL count cycles spent in REQ; if ack_i=0 in the TIMEOUT-th REQ cycle, next edge SHALL go to IDLE, pend[vec] retained, timeout_o=1 for exactly one cycle.
REQ-020 Ack in the TIMEOUT-th cycle SHALL win over timeout (go to SERV, no timeout_o).
REQ-021 Mask or pend changes during REQ/SERV SHALL NOT change vec_o or cancel the request.
REQ-022 SERV: busy_o=1, irq_o=0, vec_o held; eoi_i=1 SHALL go to IDLE at next edge; ack_i ignored.
REQ-023 eoi_i in IDLE or REQ and ack_i in IDLE or SERV SHALL be ignored.
REQ-024 Latency: intr_i sampled at edge k SHALL yield irq_o=1 after edge k+1 (from IDLE, unmasked, empty pend).
REQ-025 After eoi_i, a remaining unmasked pending source SHALL be raised with irq_o=1 one cycle after IDLE is entered (no pause beyond the IDLE cycle).
REQ-026 irq_o, busy_o, timeout_o, vec_o SHALL be decoded from registered state only (no combinational input-to-output path).

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE, pend=0, vec=0, timer=0, irq_o=0, busy_o=0, timeout_o=0, pend_o=0, vec_o=0, independent of clk_i.
REQ-028 Reset asserted in REQ or SERV SHALL abandon the request; no timeout_o pulse after release.
REQ-029 First capture SHALL occur on the first rising edge with rst_ni=1.

Verification
REQ-030 Single request: intr_i=1, x_i=2 one cycle, mask=0 -> irq_o=1 two edges later, vec_o=2; ack_i -> busy_o=1, pend_o=0000; eoi_i -> IDLE, irq_o=0.
REQ-031 Priority: pend=1010 (sources 1,3), mask=0 -> vec_o=3 first; after ack+eoi -> vec_o=1 raised next.
REQ-032 Masking: pend=0100, mask=0100 -> irq_o stays 0; clear mask -> irq_o=1, vec_o=2.
REQ-033 Timeout, TIMEOUT=4: no ack -> irq_o high exactly 4 cycles, timeout_o one-cycle pulse, pend_o bit still 1, re-raised next cycle; ack in 4th cycle -> SERV, no pulse.
REQ-034 Collision: ack_i with intr_i=1, x_i==vec_o -> pend bit remains 1, re-raised after eoi_i.
REQ-035 Async reset mid-SERV with pend=0011 -> all outputs 0 without a clock edge; idle after release.

Source files
------------

// File: rtl/intr_ctrl.sv
// Four-source interrupt controller: captures encoded requests into a pending
// register, raises the highest unmasked one to the CPU and tracks ack/eoi.
module intr_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       intr_i,
    input  logic [1:0] x_i,
    input  logic [3:0] mask_i,
    input  logic       ack_i,
    input  logic       eoi_i,
    output logic       irq_o,
    output logic [1:0] vec_o,
    output logic       busy_o,
    output logic [3:0] pend_o,
    output logic       timeout_o
);

    localparam int unsigned NSRC = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned TW   = 8;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    logic [1:0]      r_state;
    logic [NSRC-1:0] r_pend;
    logic [IDW-1:0]  r_vec;
    logic [TW-1:0]   r_timer;
    logic            r_irq;
    logic            r_busy;
    logic            r_timeout;

    logic [1:0]      w_state_nxt;
    logic [NSRC-1:0] w_pend_nxt;
    logic [IDW-1:0]  w_vec_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic            w_timeout_nxt;
    logic [NSRC-1:0] w_eligible;
    logic [IDW-1:0]  w_top;

    assign w_eligible = r_pend & ~mask_i;

    // Highest-index eligible source wins.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (w_eligible[i]) begin
                w_top = IDW'(i);
            end
        end
    end

    // Next-state, pending and timer update.
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend;
        w_vec_nxt     = r_vec;
        w_timer_nxt   = r_timer;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = ST_REQ;
                    w_vec_nxt   = w_top;
                    w_timer_nxt = '0;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    w_state_nxt        = ST_SERV;
                    w_pend_nxt[r_vec]  = 1'b0;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_SERV: begin
                if (eoi_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A new capture overrides the ack clear on the same source.
        if (intr_i) begin
            w_pend_nxt[x_i] = 1'b1;
        end
    end

    // Outputs are flopped from the next state so they track r_state exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_pend    <= '0;
            r_vec     <= '0;
            r_timer   <= '0;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_vec     <= w_vec_nxt;
            r_timer   <= w_timer_nxt;
            r_irq     <= (w_state_nxt == ST_REQ);
            r_busy    <= (w_state_nxt == ST_SERV);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign irq_o     = r_irq;
    assign vec_o     = r_vec;
    assign busy_o    = r_busy;
    assign pend_o    = r_pend;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with TIMEOUT=4; expected values hand-derived.
module tb_intr_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       intr_i;
    logic [1:0] x_i;
    logic [3:0] mask_i;
    logic       ack_i;
    logic       eoi_i;
    logic       irq_o;
    logic [1:0] vec_o;
    logic       busy_o;
    logic [3:0] pend_o;
    logic       timeout_o;

    int n_vec = 0;
    int n_err = 0;

    intr_ctrl #(.TIMEOUT(4)) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .intr_i    (intr_i),
        .x_i       (x_i),
        .mask_i    (mask_i),
        .ack_i     (ack_i),
        .eoi_i     (eoi_i),
        .irq_o     (irq_o),
        .vec_o     (vec_o),
        .busy_o    (busy_o),
        .pend_o    (pend_o),
        .timeout_o (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Packed compare: {irq, vec, busy, pend, timeout}.
    task automatic chk(input string tag, input logic e_irq, input logic [1:0] e_vec,
                       input logic e_busy, input logic [3:0] e_pend, input logic e_to);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {irq_o, vec_o, busy_o, pend_o, timeout_o};
        exp = {e_irq, e_vec, e_busy, e_pend, e_to};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed irq/vec/busy/pend/to=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        intr_i = 1'b0;
        x_i    = 2'd0;
        mask_i = 4'h0;
        ack_i  = 1'b0;
        eoi_i  = 1'b0;
        step();
        step();
        chk("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        rst_ni = 1'b1;

        // Single request on source 2
        intr_i = 1'b1; x_i = 2'd2;
        step();
        chk("single_capture", 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0);
        intr_i = 1'b0;
        step();
        chk("single_raise", 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0);
        ack_i = 1'b1;
        step();
        chk("single_ack", 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0);
        ack_i = 1'b0;
        step();
        chk("single_serv_hold", 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0);
        eoi_i = 1'b1;
        step();
        chk("single_eoi", 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);
        eoi_i = 1'b0;
        ack_i = 1'b1;
        step();
        chk("ack_in_idle_ignored", 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);
        ack_i = 1'b0;

        // Priority: sources 1 and 3 pending under full mask, then unmask
        mask_i = 4'hF;
        intr_i = 1'b1; x_i = 2'd1;
        step();
        x_i = 2'd3;
        step();
        intr_i = 1'b0;
        chk("prio_pend", 1'b0, 2'd2, 1'b0, 4'b1010, 1'b0);
        mask_i = 4'h0;
        step();
        chk("prio_first", 1'b1, 2'd3, 1'b0, 4'b1010, 1'b0);
        ack_i = 1'b1;
        step();
        chk("prio_ack", 1'b0, 2'd3, 1'b1, 4'b0010, 1'b0);
        ack_i = 1'b0; eoi_i = 1'b1;
        step();
        chk("prio_eoi", 1'b0, 2'd3, 1'b0, 4'b0010, 1'b0);
        eoi_i = 1'b0;
        step();
        chk("prio_second", 1'b1, 2'd1, 1'b0, 4'b0010, 1'b0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0; eoi_i = 1'b1;
        step();
        eoi_i = 1'b0;
        chk("prio_done", 1'b0, 2'd1, 1'b0, 4'b0000, 1'b0);

        // Masking, plus mask change while requesting
        mask_i = 4'b0100;
        intr_i = 1'b1; x_i = 2'd2;
        step();
        intr_i = 1'b0;
        step();
        chk("mask_blocked", 1'b0, 2'd1, 1'b0, 4'b0100, 1'b0);
        step();
        chk("mask_blocked2", 1'b0, 2'd1, 1'b0, 4'b0100, 1'b0);
        mask_i = 4'h0;
        step();
        chk("mask_cleared", 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0);
        mask_i = 4'hF;
        step();
        chk("mask_in_req", 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0; eoi_i = 1'b1;
        step();
        eoi_i = 1'b0; mask_i = 4'h0;
        chk("mask_done", 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);

        // Timeout with no ack: exactly four irq cycles, one pulse, re-raise
        intr_i = 1'b1; x_i = 2'd0;
        step();
        intr_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to_req_cyc%0d", i + 1), 1'b1, 2'd0, 1'b0, 4'b0001, 1'b0);
        end
        step();
        chk("to_pulse", 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1);
        step();
        chk("to_reraise", 1'b1, 2'd0, 1'b0, 4'b0001, 1'b0);
        step();
        step();
        step();
        chk("to_cyc4_again", 1'b1, 2'd0, 1'b0, 4'b0001, 1'b0);
        ack_i = 1'b1;
        step();
        chk("to_ack_wins", 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
        ack_i = 1'b0;
        step();
        chk("to_no_late_pulse", 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
        eoi_i = 1'b1;
        step();
        eoi_i = 1'b0;

        // Set/clear collision on ack, eoi during REQ ignored
        intr_i = 1'b1; x_i = 2'd3;
        step();
        intr_i = 1'b0;
        step();
        chk("coll_raise", 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0);
        ack_i = 1'b1; intr_i = 1'b1; x_i = 2'd3;
        step();
        ack_i = 1'b0; intr_i = 1'b0;
        chk("coll_set_wins", 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0);
        eoi_i = 1'b1;
        step();
        eoi_i = 1'b0;
        step();
        chk("coll_reraise", 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0);
        eoi_i = 1'b1;
        step();
        eoi_i = 1'b0;
        chk("eoi_in_req_ignored", 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0; eoi_i = 1'b1;
        step();
        eoi_i = 1'b0;

        // Async reset in SERV with pend=0011
        mask_i = 4'hF;
        intr_i = 1'b1; x_i = 2'd0;
        step();
        x_i = 2'd1;
        step();
        intr_i = 1'b0; mask_i = 4'h0;
        step();
        chk("rst_setup_req", 1'b1, 2'd1, 1'b0, 4'b0011, 1'b0);
        ack_i = 1'b1; intr_i = 1'b1; x_i = 2'd1;
        step();
        ack_i = 1'b0; intr_i = 1'b0;
        chk("rst_setup_serv", 1'b0, 2'd1, 1'b1, 4'b0011, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        step();
        rst_ni = 1'b1;
        step();
        chk("post_reset_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        step();
        chk("post_reset_idle2", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
